// File: rtl/collector_pkg.sv
// Shared types and helpers for the core result collector.
// Holds the collector state encoding and a clog2 used for parameter checks.
package collector_pkg;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    COMPLETE = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++)
      if ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/core_result_collector_if.sv
// Child-core result bus: per-core completion flag plus two result values.
// master = child cores (drive), slave = collector (sample).
interface core_result_collector_if #(
  parameter int NUM_CORES  = 30,
  parameter int DATA_WIDTH = 32
);

  logic [NUM_CORES-1:0]            buf_flag;
  logic [NUM_CORES*DATA_WIDTH-1:0] buf_val_1_flat;
  logic [NUM_CORES*DATA_WIDTH-1:0] buf_val_2_flat;

  modport master (
    output buf_flag,
    output buf_val_1_flat,
    output buf_val_2_flat
  );

  modport slave (
    input buf_flag,
    input buf_val_1_flat,
    input buf_val_2_flat
  );

endinterface

// File: rtl/core_result_collector_slot.sv
// One per-core result slot: flag edge detect, two data regs, sticky done.
// Ports: flag/val_1/val_2/clear in; done, done_nxt, data_1, data_2 out.
module result_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flag,
  input  logic [DATA_WIDTH-1:0] val_1,
  input  logic [DATA_WIDTH-1:0] val_2,
  input  logic                  clear,
  output logic                  done,
  output logic                  done_nxt,
  output logic [DATA_WIDTH-1:0] data_1,
  output logic [DATA_WIDTH-1:0] data_2
);

  logic flag_q;
  logic cap;

  // A rising edge coinciding with clear starts the new round captured.
  assign cap      = flag & ~flag_q & (~done | clear);
  assign done_nxt = cap | (done & ~clear);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      done   <= 1'b0;
      data_1 <= '0;
      data_2 <= '0;
    end else begin
      flag_q <= flag;
      done   <= done_nxt;
      if (cap) begin
        data_1 <= val_1;
        data_2 <= val_2;
      end
    end
  end

endmodule

// File: rtl/core_result_collector.sv
// Collects per-core result pairs, tracks completion, watchdog and reads.
// Ports: Clk, Reset, cores bus, clear, dual read port, done/status outputs.
module core_result_collector
  import collector_pkg::*;
#(
  parameter int NUM_CORES      = 30,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_WIDTH      = 7
) (
  input  logic                  Clk,
  input  logic                  Reset,
  core_result_collector_if.slave cores,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] rd_addr_1,
  input  logic [ADDR_WIDTH-1:0] rd_addr_2,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  output logic [DATA_WIDTH-1:0] rd_data_2,
  output logic [NUM_CORES-1:0]  done_mask,
  output logic [CNT_WIDTH-1:0]  done_count,
  output logic                  all_buf_flags,
  output logic                  timeout
);

  if (NUM_CORES < 1 || NUM_CORES > 64) begin : g_bad_n
    $error("NUM_CORES out of range");
  end
  if (clog2(NUM_CORES) > ADDR_WIDTH) begin : g_bad_a
    $error("ADDR_WIDTH too small");
  end
  if (clog2(NUM_CORES + 1) > CNT_WIDTH) begin : g_bad_c
    $error("CNT_WIDTH too small");
  end

  localparam int  DEPTH = 2 ** ADDR_WIDTH;
  localparam bit  WD_EN = TIMEOUT_CYCLES != 0;
  localparam int  WD_T  = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES : 2;
  localparam int  WD_W  = clog2(WD_T);
  localparam int  WD_L  = WD_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WD_L);

  logic [DATA_WIDTH-1:0] d1 [NUM_CORES];
  logic [DATA_WIDTH-1:0] d2 [NUM_CORES];
  logic [DATA_WIDTH-1:0] pad1 [DEPTH];
  logic [DATA_WIDTH-1:0] pad2 [DEPTH];
  logic [NUM_CORES-1:0]  done_nxt;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic [WD_W-1:0]       wd_cnt;
  logic                  full;
  logic                  to_set;
  state_t                state;
  state_t                st_nxt;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
    result_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk     (Clk),
      .rst_n   (Reset),
      .flag    (cores.buf_flag[i]),
      .val_1   (cores.buf_val_1_flat[i*DATA_WIDTH +: DATA_WIDTH]),
      .val_2   (cores.buf_val_2_flat[i*DATA_WIDTH +: DATA_WIDTH]),
      .clear   (clear),
      .done    (done_mask[i]),
      .done_nxt(done_nxt[i]),
      .data_1  (d1[i]),
      .data_2  (d2[i])
    );
  end

  assign full = &done_nxt;

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_CORES; i++)
      cnt_nxt = cnt_nxt + CNT_WIDTH'(done_nxt[i]);
  end

  // Out-of-range addresses land on zero-filled entries.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      pad1[i] = '0;
      pad2[i] = '0;
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      pad1[i] = d1[i];
      pad2[i] = d2[i];
    end
  end

  always_comb begin
    st_nxt = state;
    to_set = 1'b0;
    unique case (state)
      COLLECT: begin
        if (full) begin
          st_nxt = COMPLETE;
        end else if (WD_EN && wd_cnt == WD_LIM) begin
          st_nxt = TIMEOUT;
          to_set = 1'b1;
        end
      end
      TIMEOUT:  if (full) st_nxt = COMPLETE;
      COMPLETE: st_nxt = COMPLETE;
      default:  st_nxt = COLLECT;
    endcase
    if (clear) begin
      st_nxt = full ? COMPLETE : COLLECT;
      to_set = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= COLLECT;
      timeout    <= 1'b0;
      wd_cnt     <= '0;
      done_count <= '0;
      rd_data_1  <= '0;
      rd_data_2  <= '0;
    end else begin
      state      <= st_nxt;
      done_count <= cnt_nxt;
      rd_data_1  <= pad1[rd_addr_1];
      rd_data_2  <= pad2[rd_addr_2];
      if (clear)
        timeout <= 1'b0;
      else if (to_set)
        timeout <= 1'b1;
      if (clear)
        wd_cnt <= '0;
      else if (state == COLLECT && wd_cnt != '1)
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign all_buf_flags = (state == COMPLETE);

endmodule

// File: doc/core_result_collector.md
Name: core_result_collector

Overview:
Parametrised successor to the fixed 30-core buffer interconnect between the child cores and the parent core. Each child presents a result pair and a completion flag. The block captures each pair into a per-core slot on the flag's rising edge and tracks completion with sticky done bits. It gives the parent a registered dual read port, a completion status and a watchdog timeout. The parent can re-arm the block for a new round without resetting the cores.

Parameters:
NUM_CORES, 30, number of child cores (1..64)
DATA_WIDTH, 32, width of each result value
ADDR_WIDTH, 6, width of the slot read addresses; must satisfy 2^ADDR_WIDTH >= NUM_CORES
TIMEOUT_CYCLES, 0, watchdog limit in cycles since the last clear/reset; 0 disables the watchdog
CNT_WIDTH, 7, width of done_count; must satisfy 2^CNT_WIDTH > NUM_CORES

Ports:
Clk  in  1  single clock; all state updates on the rising edge
Reset  in  1  asynchronous, active-low reset
buf_flag  in  NUM_CORES  per-core completion flag
buf_val_1_flat  in  NUM_CORES*DATA_WIDTH  first result value per core; core i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
buf_val_2_flat  in  NUM_CORES*DATA_WIDTH  second result value per core, same packing
clear  in  1  single-cycle pulse from the parent: re-arm all slots and restart the watchdog
rd_addr_1  in  ADDR_WIDTH  slot index for read port 1
rd_addr_2  in  ADDR_WIDTH  slot index for read port 2
rd_data_1  out  DATA_WIDTH  val_1 of slot rd_addr_1, registered
rd_data_2  out  DATA_WIDTH  val_2 of slot rd_addr_2, registered
done_mask  out  NUM_CORES  sticky per-slot done bits
done_count  out  CNT_WIDTH  population count of done_mask
all_buf_flags  out  1  high exactly while state is COMPLETE
timeout  out  1  sticky watchdog expiry flag

Behaviour:
- Reset (Reset low, asynchronous):
  - all slot data, done_mask, done_count, flag history, rd_data_1/2, timeout and watchdog counter = 0
  - state = COLLECT
- Edge detect: flag_q[i] registers buf_flag[i] every cycle; flag_q resets to 0.
  - Consequence: a flag already high when reset releases counts as a rising edge on the first cycle.
- Capture: if buf_flag[i] & ~flag_q[i] & ~done_mask[i], slot i latches val_1 and val_2 and done_mask[i] is set, all on the same edge.
  - Further edges on a done slot are ignored; the slot's data is frozen until clear.
- Multiple cores rising in the same cycle are all captured; there is no arbitration.
- clear:
  - all done bits and done_count go to 0; the watchdog counter goes to 0; timeout goes to 0; state goes to COLLECT
  - slot data is retained, not zeroed
  - if a rising edge on core i coincides with clear, the capture wins for slot i: done_mask[i] = 1 with the new data after that edge, counted in the new round
- done_count is registered, equals popcount(done_mask) and is updated on the same edge as done_mask.
- State machine:
  - COLLECT -> COMPLETE when the next done_mask is all ones
  - COLLECT -> TIMEOUT when TIMEOUT_CYCLES != 0, the counter reaches TIMEOUT_CYCLES-1 and the next done_mask is not all ones; timeout is set on that transition
  - TIMEOUT -> COMPLETE when late captures complete the mask; timeout stays high
  - COMPLETE holds until clear; clear returns to COLLECT from any state
- all_buf_flags rises on the same edge that sets the last done bit, i.e. zero added latency versus done_mask.
- Watchdog counter increments only in COLLECT and saturates.
- Read ports:
  - rd_data_n = slot[rd_addr_n] registered, 1-cycle latency
  - an address >= NUM_CORES returns 0
  - reading a slot on the cycle it captures returns the old data; the new data appears on the next read

Decomposition:
- Shared package collector_pkg holds:
  - state enum: COLLECT=2'd0, COMPLETE=2'd1, TIMEOUT=2'd2
  - a clog2 function used for parameter checks
- One sub-module, result_slot, instanced NUM_CORES times via a generate loop. It contains the flag_q edge detect, the two data registers and the done bit, with inputs flag, val_1, val_2, clear and outputs done, data_1, data_2.
- The top level contains the popcount, the FSM, the watchdog and the read muxes.

Test Plan:
1. NUM_CORES=4, reset released, flags rise in cycles 3,5,5,9 with val_1=10+i, val_2=20+i -> done_count goes 1,3,4; all_buf_flags rises at the cycle-9 edge; rd_addr_1=2 returns 12 one cycle later.
2. Core 1 flag toggles 0->1->0->1 with new data 0xAA then 0xBB -> slot 1 keeps 0xAA; done_count unchanged by the second edge.
3. TIMEOUT_CYCLES=16, only 3 of 4 cores flag -> timeout and state TIMEOUT at cycle 16 with all_buf_flags=0; core 3 then flags -> all_buf_flags=1 and timeout stays 1.
4. clear pulsed in the same cycle as core 0's rising edge with all slots done -> done_mask=4'b0001, done_count=1, timeout=0, state COLLECT.
5. rd_addr_2=7 with NUM_CORES=4 -> rd_data_2=0; Reset asserted mid-round -> every output is 0 immediately, without waiting for a clock edge.
